uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the UART transmit FIFO write port (2..8).
REQ-002 Parameter WIDTH, default 8, data byte width.
REQ-003 Parameter MAX_BURST, default 16, maximum beats per grant before forced release (1..255).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester beat valid.
REQ-007 req_data  input  NREQ*WIDTH  per-requester byte; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_last  input  NREQ  marks final beat of requester's burst.
REQ-009 req_ack  output  NREQ  one-hot beat-accepted pulse.
REQ-010 grant  output  NREQ  one-hot current owner; all-zero when idle.
REQ-011 fifo_full  input  1  UART transmit FIFO cannot accept a write.
REQ-012 fifo_wr_en  output  1  write strobe to the UART transmit FIFO (tx_data_w_en).
REQ-013 fifo_wr_data  output  WIDTH  byte to the UART transmit FIFO.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, XFER; encoding is free.
REQ-016 IDLE: with any req_valid high, select the first valid requester scanning upward from rr_ptr with wrap; register grant one-hot, go to XFER; beat counter cleared.
REQ-017 IDLE with no req_valid: stay IDLE, grant=0, no ack, no write.
REQ-018 Arbitration costs exactly one cycle; the first beat is accepted no earlier than the cycle after req_valid is first seen in IDLE.
REQ-019 Accept condition: state XFER AND req_valid[g] AND NOT fifo_full, where g is the granted index.
REQ-020 On accept, in the same cycle (combinational): req_ack[g]=1, fifo_wr_en=1, fifo_wr_data=req_data[g]; otherwise req_ack=0, fifo_wr_en=0, fifo_wr_data=0.
REQ-021 fifo_full high or req_valid[g] low in XFER: stall; grant held; no ack; beat counter unchanged.
REQ-022 Release: accepted beat with req_last[g]=1, or accepted beat bringing the beat count to MAX_BURST; next state IDLE, grant=0, rr_ptr=(g+1) mod NREQ.
REQ-023 Non-granted requesters never receive ack; their req_valid/data are ignored until granted.
REQ-024 req_last on a non-accepted cycle has no effect.
REQ-025 Beat counter width ceil(log2(MAX_BURST+1)); never wraps, since release occurs at MAX_BURST.
REQ-026 MAX_BURST=1: each accepted beat releases the grant regardless of req_last.
REQ-027 Strict round-robin: a requester valid continuously is granted within NREQ-1 other bursts.

Reset
REQ-028 rst asserted: immediately state=IDLE, grant=0, rr_ptr=0, beat counter=0, busy=0, req_ack=0, fifo_wr_en=0, fifo_wr_data=0.
REQ-029 rst mid-burst abandons the burst with no further write; the first grant after rst release goes to the lowest valid index.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: in XFER, a stall counter counts consecutive cycles with req_valid[g]=0 (fifo_full stalls are not counted); on reaching 16, release per REQ-022 without a write, and pulse an extra output timeout (1 bit, registered, reset 0) for one cycle.
REQ-031 Macro UART_ARB_TIMEOUT_EN undefined: no stall counter and no timeout port; a granted requester holds the grant indefinitely until last or MAX_BURST.

Verification
REQ-032 Single requester 1 sends bytes 0x41,0x42,0x43 (last on 0x43), fifo_full=0 -> grant=0010 one cycle after valid; three consecutive writes 0x41,0x42,0x43; IDLE the cycle after; rr_ptr=2.
REQ-033 Requesters 0 and 2 both valid after reset, single-beat bursts 0xA0/0xA2 -> write order 0xA0 then 0xA2; no ack to requester 2 while requester 0 is granted.
REQ-034 Requester 3 streams 20 beats with no last, MAX_BURST=16 -> exactly 16 writes, release, one IDLE cycle, then a new grant covering remaining beats.
REQ-035 fifo_full held high for 5 cycles mid-burst -> zero writes and acks during those cycles; grant stable; burst resumes with the same byte.
REQ-036 rst pulsed while requester 1 is mid-burst -> fifo_wr_en=0 and grant=0 in the reset cycle; after release, a request from requester 0 is granted first.
REQ-037 With UART_ARB_TIMEOUT_EN: granted requester drops valid for 16 cycles -> timeout pulses once, grant=0, no write.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter_if : requester/FIFO-side bundle for uart_tx_arbiter.
// Optional timeout signal present when UART_ARB_TIMEOUT_EN is defined. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       grant;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic                  busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic                  timeout;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ack, grant, fifo_wr_en, fifo_wr_data, busy, timeout
  );
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ack, grant, fifo_wr_en, fifo_wr_data, busy, timeout
  );
`else
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ack, grant, fifo_wr_en, fifo_wr_data, busy
  );
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ack, grant, fifo_wr_en, fifo_wr_data, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter : round-robin burst arbiter onto one UART TX FIFO write port.
// Define UART_ARB_TIMEOUT_EN to release stalled owners after 16 idle cycles. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  uart_tx_arbiter_if.slave    arb_if
);

  localparam int c_IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_CNTW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [NREQ-1:0]     r_grant,    w_grant_nxt;
  logic [c_IDXW-1:0]   r_gidx,     w_gidx_nxt;
  logic [c_IDXW-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
  logic [c_CNTW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [c_CNTW-1:0]   w_beat_inc;
  logic [c_IDXW-1:0]   w_gidx_inc;
  logic [c_IDXW-1:0]   w_sel_idx;
  logic                w_sel_found;
  logic                w_accept;
  logic                w_release;
`ifdef UART_ARB_TIMEOUT_EN
  logic [4:0]          r_stall_cnt, w_stall_nxt;
  logic                r_timeout,   w_timeout_nxt;
  logic                w_stall_hit;
`endif

  // Scan downward so the candidate closest to r_rr_ptr is the last one written.
  always_comb begin
    int j;
    j           = 0;
    w_sel_idx   = '0;
    w_sel_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (arb_if.req_valid[c_IDXW'(j)]) begin
        w_sel_idx   = c_IDXW'(j);
        w_sel_found = 1'b1;
      end
    end
  end

  assign w_gidx_inc = (r_gidx == c_IDXW'(NREQ - 1)) ? '0 : r_gidx + c_IDXW'(1);
  assign w_beat_inc = r_beat_cnt + c_CNTW'(1);
  assign w_accept   = (r_state == ST_XFER) && arb_if.req_valid[r_gidx] && !arb_if.fifo_full;
  assign w_release  = w_accept &&
                      (arb_if.req_last[r_gidx] || (w_beat_inc == c_CNTW'(MAX_BURST)));

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_gidx_nxt     = r_gidx;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
`ifdef UART_ARB_TIMEOUT_EN
    w_stall_nxt    = r_stall_cnt;
    w_timeout_nxt  = 1'b0;
    w_stall_hit    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (w_sel_found) begin
          w_state_nxt    = ST_XFER;
          w_grant_nxt    = NREQ'(1) << w_sel_idx;
          w_gidx_nxt     = w_sel_idx;
          w_beat_cnt_nxt = '0;
`ifdef UART_ARB_TIMEOUT_EN
          w_stall_nxt    = '0;
`endif
        end
      end
      ST_XFER: begin
        if (w_accept) w_beat_cnt_nxt = w_beat_inc;
`ifdef UART_ARB_TIMEOUT_EN
        // Only an absent requester ages the grant; FIFO back-pressure does not.
        if (!arb_if.req_valid[r_gidx]) begin
          w_stall_nxt = r_stall_cnt + 5'd1;
          w_stall_hit = (r_stall_cnt == 5'd15);
        end else begin
          w_stall_nxt = '0;
        end
        if (w_stall_hit) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_rr_ptr_nxt   = w_gidx_inc;
          w_beat_cnt_nxt = '0;
          w_stall_nxt    = '0;
          w_timeout_nxt  = 1'b1;
        end
`endif
        if (w_release) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_rr_ptr_nxt   = w_gidx_inc;
          w_beat_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign arb_if.timeout = r_timeout;
`endif

  assign arb_if.req_ack      = w_accept ? r_grant : '0;
  assign arb_if.fifo_wr_en   = w_accept;
  assign arb_if.fifo_wr_data = w_accept ? arb_if.req_data[r_gidx*WIDTH +: WIDTH] : '0;
  assign arb_if.grant        = r_grant;
  assign arb_if.busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// tb_uart_tx_arbiter : directed self-checking bench for uart_tx_arbiter
// (NREQ=4, WIDTH=8, MAX_BURST=16). Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  uart_tx_arbiter_if #(.NREQ(4), .WIDTH(8)) u_if ();

  uart_tx_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(16)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [7:0] val);
    u_if.req_data[idx*8 +: 8] = val;
  endtask

  function automatic logic [31:0] wr();
    return {23'd0, u_if.fifo_wr_en, u_if.fifo_wr_data};
  endfunction

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst               = 1'b1;
    u_if.req_valid    = '0;
    u_if.req_data     = '0;
    u_if.req_last     = '0;
    u_if.fifo_full    = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_grant", u_if.grant, 0);
    chk("rst_busy",  u_if.busy, 0);
    chk("rst_wr",    wr(), 0);
    chk("rst_ack",   u_if.req_ack, 0);
    tick();
    rst = 1'b0;

    // Single requester 1, three beats
    tick();
    u_if.req_valid = 4'b0010; set_data(1, 8'h41);
    @(negedge clk);
    chk("t1_arb_grant", u_if.grant, 0);
    chk("t1_arb_wr",    wr(), 0);
    tick();
    @(negedge clk);
    chk("t1_grant", u_if.grant, 4'b0010);
    chk("t1_ack",   u_if.req_ack, 4'b0010);
    chk("t1_busy",  u_if.busy, 1);
    chk("t1_wr41",  wr(), 9'h141);
    tick();
    set_data(1, 8'h42);
    @(negedge clk);
    chk("t1_wr42", wr(), 9'h142);
    tick();
    set_data(1, 8'h43); u_if.req_last = 4'b0010;
    @(negedge clk);
    chk("t1_wr43", wr(), 9'h143);
    tick();
    u_if.req_valid = '0; u_if.req_last = '0;
    @(negedge clk);
    chk("t1_idle_busy",  u_if.busy, 0);
    chk("t1_idle_grant", u_if.grant, 0);
    // rr_ptr should now be 2: with 0,1,2 all valid, requester 2 wins
    tick();
    u_if.req_valid = 4'b0111; u_if.req_last = 4'b0111;
    set_data(0, 8'h10); set_data(1, 8'h11); set_data(2, 8'h12);
    tick();
    @(negedge clk);
    chk("t1_rr_grant", u_if.grant, 4'b0100);
    chk("t1_rr_wr",    wr(), 9'h112);
    tick();
    u_if.req_valid = '0; u_if.req_last = '0;

    // Fresh reset, requesters 0 and 2 single-beat
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_if.req_valid = 4'b0101; u_if.req_last = 4'b0101;
    set_data(0, 8'hA0); set_data(2, 8'hA2);
    tick();
    @(negedge clk);
    chk("t2_grant0", u_if.grant, 4'b0001);
    chk("t2_ack0",   u_if.req_ack, 4'b0001);
    chk("t2_wrA0",   wr(), 9'h1A0);
    tick();
    u_if.req_valid = 4'b0100;
    @(negedge clk);
    chk("t2_gap_wr",  wr(), 0);
    chk("t2_gap_ack", u_if.req_ack, 0);
    tick();
    @(negedge clk);
    chk("t2_grant2", u_if.grant, 4'b0100);
    chk("t2_wrA2",   wr(), 9'h1A2);
    tick();
    u_if.req_valid = '0; u_if.req_last = '0;

    // fifo_full stall mid-burst on requester 1
    tick();
    u_if.req_valid = 4'b0010; set_data(1, 8'h50);
    tick();
    @(negedge clk);
    chk("t3_wr50", wr(), 9'h150);
    tick();
    set_data(1, 8'h51); u_if.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_wr",    wr(), 0);
      chk("t3_stall_ack",   u_if.req_ack, 0);
      chk("t3_stall_grant", u_if.grant, 4'b0010);
      if (i < 4) tick();
    end
    tick();
    u_if.fifo_full = 1'b0;
    @(negedge clk);
    chk("t3_wr51", wr(), 9'h151);
    tick();
    set_data(1, 8'h52); u_if.req_last = 4'b0010;
    @(negedge clk);
    chk("t3_wr52", wr(), 9'h152);
    tick();
    u_if.req_valid = '0; u_if.req_last = '0;

    // Reset mid-burst on requester 1
    tick();
    u_if.req_valid = 4'b0010; set_data(1, 8'h60);
    tick();
    @(negedge clk);
    chk("t4_wr60", wr(), 9'h160);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_wr",    wr(), 0);
    chk("t4_rst_grant", u_if.grant, 0);
    chk("t4_rst_busy",  u_if.busy, 0);
    tick();
    rst = 1'b0;
    u_if.req_valid = 4'b0011; u_if.req_last = 4'b0001; set_data(0, 8'h70);
    tick();
    @(negedge clk);
    chk("t4_grant0", u_if.grant, 4'b0001);
    chk("t4_wr70",   wr(), 9'h170);
    tick();
    u_if.req_valid = 4'b0010; u_if.req_last = 4'b0010;
    tick();
    @(negedge clk);
    chk("t4_grant1", u_if.grant, 4'b0010);
    tick();
    u_if.req_valid = '0; u_if.req_last = '0;

    // Requester 3 streams 20 beats, forced release after 16
    tick();
    u_if.req_valid = 4'b1000; set_data(3, 8'h80);
    for (int i = 0; i < 16; i++) begin
      tick();
      set_data(3, 8'(8'h80 + i));
      @(negedge clk);
      chk("t5_beat", wr(), 32'h180 + i);
    end
    tick();
    set_data(3, 8'h90);
    @(negedge clk);
    chk("t5_rel_busy", u_if.busy, 0);
    chk("t5_rel_wr",   wr(), 0);
    for (int i = 16; i < 20; i++) begin
      tick();
      set_data(3, 8'(8'h80 + i));
      u_if.req_last = (i == 19) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      chk("t5_tail", wr(), 32'h180 + i);
    end
    tick();
    u_if.req_valid = '0; u_if.req_last = '0;
    @(negedge clk);
    chk("t5_end_busy", u_if.busy, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Requester 0 goes silent for 16 cycles
    tick();
    u_if.req_valid = 4'b0001; set_data(0, 8'h33);
    tick();
    @(negedge clk);
    chk("t6_wr33", wr(), 9'h133);
    tick();
    u_if.req_valid = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("t6_hold_grant", u_if.grant, 4'b0001);
      chk("t6_hold_to",    u_if.timeout, 0);
      if (k < 16) tick();
    end
    tick();
    @(negedge clk);
    chk("t6_to_pulse", u_if.timeout, 1);
    chk("t6_to_grant", u_if.grant, 0);
    chk("t6_to_wr",    wr(), 0);
    tick();
    @(negedge clk);
    chk("t6_to_clear", u_if.timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
